// File: rtl/whack_mole_engine.sv
// Whack-a-Mole game engine: an LFSR picks a lit hole, switch toggles score hits or misses,
// and each round ends on a toggle or a timeout. Drives the LED bank and the score counters.
module whack_mole_engine #(
  parameter int          N_HOLES        = 16,
  parameter int          ROUNDS         = 32,
  parameter int          SCORE_W        = 6,
  parameter int          TIMEOUT_CYCLES = 100000000,
  parameter int          TMR_W          = 27,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_HOLES-1:0] sw,
  output logic [N_HOLES-1:0] LED,
  output logic [SCORE_W-1:0] score_count,
  output logic [SCORE_W-1:0] miss_count,
  output logic [7:0]         round_count,
  output logic               game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SCORE_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [N_HOLES-1:0] sw_q, sw_d;
  logic [3:0]         target_q, target_d;
  logic [4:0]         prev_q, prev_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] miss_q, miss_d;
  logic [7:0]         round_q, round_d;

  logic [N_HOLES-1:0] tog;
  logic [N_HOLES-1:0] target_oh;
  logic [3:0]         cand;
  logic               cand_ok;
  logic               timed_out;

  always_comb begin
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    sw_d      = sw;
    tog       = sw ^ sw_q;
    target_oh = N_HOLES'(1) << target_q;
    cand      = lfsr_q[3:0];
    cand_ok   = (int'(cand) < N_HOLES) && ({1'b0, cand} != prev_q);
    timed_out = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST);

    state_d  = state_q;
    target_d = target_q;
    prev_d   = prev_q;
    timer_d  = timer_q;
    score_d  = score_q;
    miss_d   = miss_q;
    round_d  = round_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          score_d = '0;
          miss_d  = '0;
          round_d = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (cand_ok) begin
          target_d = cand;
          prev_d   = {1'b0, cand};
          timer_d  = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // A hit requires exactly the lit switch; any extra toggle turns it into a miss.
        if (tog == target_oh) begin
          if (score_q != CNT_MAX) score_d = score_q + SCORE_W'(1);
          round_d = round_q + 8'd1;
          state_d = S_GAP;
        end else if ((tog != '0) || timed_out) begin
          if (miss_q != CNT_MAX) miss_d = miss_q + SCORE_W'(1);
          round_d = round_q + 8'd1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = (round_q == 8'(ROUNDS)) ? S_DONE : S_ARM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    LED = '0;
    case (state_q)
      S_WAIT:  LED = target_oh;
      S_DONE:  LED = '1;
      default: LED = '0;
    endcase
    game_over   = (state_q == S_DONE);
    score_count = score_q;
    miss_count  = miss_q;
    round_count = round_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      sw_q     <= sw;
      target_q <= '0;
      prev_q   <= 5'(N_HOLES);
      timer_q  <= '0;
      score_q  <= '0;
      miss_q   <= '0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      sw_q     <= sw_d;
      target_q <= target_d;
      prev_q   <= prev_d;
      timer_q  <= timer_d;
      score_q  <= score_d;
      miss_q   <= miss_d;
      round_q  <= round_d;
    end
  end

endmodule

// File: tb/tb_whack_mole_engine.sv
// Self-checking bench for whack_mole_engine: a small 4-hole game with a 20-cycle timeout and
// a 5-hole 200-round game with a 3-bit score, driven by random play against a score model.
module tb_whack_mole_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [3:0] sw_a, led_a;
  logic [5:0] score_a, miss_a;
  logic [7:0] round_a;
  logic       over_a;
  logic [4:0] sw_b, led_b;
  logic [2:0] score_b, miss_b;
  logic [7:0] round_b;
  logic       over_b;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_score, exp_miss, exp_round;
  int last_idx_a = -1;

  always #5 clk = ~clk;

  whack_mole_engine #(
    .N_HOLES(4), .ROUNDS(3), .SCORE_W(6), .TIMEOUT_CYCLES(20), .TMR_W(5), .LFSR_SEED(16'hACE1)
  ) u_a (
    .clk(clk), .reset(reset), .start(start_a), .sw(sw_a), .LED(led_a),
    .score_count(score_a), .miss_count(miss_a), .round_count(round_a), .game_over(over_a)
  );

  whack_mole_engine #(
    .N_HOLES(5), .ROUNDS(200), .SCORE_W(3), .TIMEOUT_CYCLES(0), .TMR_W(1), .LFSR_SEED(16'hACE1)
  ) u_b (
    .clk(clk), .reset(reset), .start(start_b), .sw(sw_b), .LED(led_b),
    .score_count(score_b), .miss_count(miss_b), .round_count(round_b), .game_over(over_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_lit_a(output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if ($onehot(led_a)) begin
        ok = 1'b1;
        for (int b = 0; b < 4; b++) if (led_a[b]) idx = b;
      end
    end
  endtask

  // action: 0 hit, 1 wrong switch, 2 target plus another switch, 3 let it time out
  task automatic play_round_a(input int action, input int delay, output int idx,
                              output bit ok, output int lit);
    wait_lit_a(idx, ok);
    lit = 1;
    if (!ok) return;
    case (action)
      0: begin
        repeat (delay) tick();
        sw_a[idx] = ~sw_a[idx];
        tick();
      end
      1: begin
        repeat (delay) tick();
        sw_a[(idx + 1) % 4] = ~sw_a[(idx + 1) % 4];
        tick();
      end
      2: begin
        repeat (delay) tick();
        sw_a[idx] = ~sw_a[idx];
        sw_a[(idx + 2) % 4] = ~sw_a[(idx + 2) % 4];
        tick();
      end
      default: begin
        for (int i = 0; i < 40; i++) begin
          tick();
          if (led_a != (4'b0001 << idx)) break;
          lit++;
        end
      end
    endcase
    exp_round++;
    if (action == 0) exp_score = (exp_score < 63) ? exp_score + 1 : 63;
    else             exp_miss  = (exp_miss  < 63) ? exp_miss  + 1 : 63;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    sw_a    = '0;
    sw_b    = '0;
    tick();
    tick();
    n_checks++;
    if ({led_a, score_a, miss_a, round_a, over_a} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_a: got led=%h score=%0d miss=%0d round=%0d over=%b, want all 0",
               led_a, score_a, miss_a, round_a, over_a);
    end
    n_checks++;
    if ({led_b, score_b, miss_b, round_b, over_b} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_b: got led=%h score=%0d miss=%0d round=%0d over=%b, want all 0",
               led_b, score_b, miss_b, round_b, over_b);
    end
    reset = 1'b0;
    repeat (3) tick();
    sw_a = 4'b0101;
    tick();
    tick();
    n_checks++;
    if (led_a !== 4'h0 || miss_a !== 6'd0) begin
      n_fail++;
      $display("[TB] FAIL idle_ignore: got led=%h miss=%0d, want led=0 miss=0", led_a, miss_a);
    end
  endtask

  task automatic test_hits;
    int idx, lit;
    bit ok;
    exp_score = 0; exp_miss = 0; exp_round = 0;
    pulse_start_a();
    for (int r = 0; r < 3; r++) begin
      play_round_a(0, $urandom_range(0, 5), idx, ok, lit);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("[TB] FAIL hits_lit: got no lit target in round %0d, want one-hot LED", r);
      end
      n_checks++;
      if (idx == last_idx_a) begin
        n_fail++;
        $display("[TB] FAIL hits_repeat: got target %0d twice in a row, want different", idx);
      end
      last_idx_a = idx;
      n_checks++;
      if (led_a !== 4'h0 || score_a !== 6'(exp_score) || round_a !== 8'(exp_round)) begin
        n_fail++;
        $display("[TB] FAIL hits_gap: got led=%h score=%0d round=%0d, want led=0 score=%0d round=%0d",
                 led_a, score_a, round_a, exp_score, exp_round);
      end
    end
    tick();
    n_checks++;
    if (over_a !== 1'b1 || led_a !== 4'hF || score_a !== 6'd3 || miss_a !== 6'd0 || round_a !== 8'd3) begin
      n_fail++;
      $display("[TB] FAIL hits_done: got over=%b led=%h score=%0d miss=%0d round=%0d, want 1 f 3 0 3",
               over_a, led_a, score_a, miss_a, round_a);
    end
  endtask

  task automatic test_timeout;
    int idx, lit;
    bit ok;
    exp_score = 0; exp_miss = 0; exp_round = 0;
    pulse_start_a();
    n_checks++;
    if (score_a !== 6'd0 || round_a !== 8'd0 || over_a !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timeout_clear: got score=%0d round=%0d over=%b, want 0 0 0",
               score_a, round_a, over_a);
    end
    for (int r = 0; r < 3; r++) begin
      play_round_a(3, 0, idx, ok, lit);
      if (ok) last_idx_a = idx;
      n_checks++;
      if (!ok || lit != 20) begin
        n_fail++;
        $display("[TB] FAIL timeout_len: got lit=%0d cycles (ok=%b), want 20", lit, ok);
      end
      n_checks++;
      if (led_a !== 4'h0 || miss_a !== 6'(exp_miss)) begin
        n_fail++;
        $display("[TB] FAIL timeout_gap: got led=%h miss=%0d, want led=0 miss=%0d", led_a, miss_a, exp_miss);
      end
    end
    tick();
    n_checks++;
    if (over_a !== 1'b1 || miss_a !== 6'd3 || score_a !== 6'd0) begin
      n_fail++;
      $display("[TB] FAIL timeout_done: got over=%b miss=%0d score=%0d, want 1 3 0", over_a, miss_a, score_a);
    end
  endtask

  task automatic test_wrong_toggle;
    int idx, lit;
    bit ok;
    int acts[3] = '{1, 2, 0};
    exp_score = 0; exp_miss = 0; exp_round = 0;
    pulse_start_a();
    for (int r = 0; r < 3; r++) begin
      play_round_a(acts[r], $urandom_range(0, 4), idx, ok, lit);
      if (ok) last_idx_a = idx;
      n_checks++;
      if (!ok || led_a !== 4'h0 || score_a !== 6'(exp_score) || miss_a !== 6'(exp_miss)) begin
        n_fail++;
        $display("[TB] FAIL wrong_act%0d: got ok=%b led=%h score=%0d miss=%0d, want led=0 score=%0d miss=%0d",
                 acts[r], ok, led_a, score_a, miss_a, exp_score, exp_miss);
      end
    end
    tick();
    n_checks++;
    if (over_a !== 1'b1 || score_a !== 6'd1 || miss_a !== 6'd2) begin
      n_fail++;
      $display("[TB] FAIL wrong_done: got over=%b score=%0d miss=%0d, want 1 1 2", over_a, score_a, miss_a);
    end
  endtask

  task automatic test_start_in_wait;
    int idx, lit;
    bit ok;
    logic [3:0] held;
    exp_score = 0; exp_miss = 0; exp_round = 0;
    pulse_start_a();
    n_checks++;
    if (over_a !== 1'b0 || led_a !== 4'h0 || score_a !== 6'd0 || miss_a !== 6'd0 || round_a !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL restart_clear: got over=%b led=%h score=%0d miss=%0d round=%0d, want all 0",
               over_a, led_a, score_a, miss_a, round_a);
    end
    wait_lit_a(idx, ok);
    held = led_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_checks++;
    if (!ok || led_a !== held || round_a !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL start_in_wait: got ok=%b led=%h round=%0d, want led=%h round=0",
               ok, led_a, round_a, held);
    end
    if (ok) begin
      last_idx_a = idx;
      sw_a[idx] = ~sw_a[idx];
      tick();
      exp_score = 1;
      exp_round = 1;
    end
    for (int r = 1; r < 3; r++) begin
      play_round_a(0, 0, idx, ok, lit);
      if (ok) last_idx_a = idx;
    end
    tick();
    n_checks++;
    if (over_a !== 1'b1 || score_a !== 6'(exp_score) || round_a !== 8'd3) begin
      n_fail++;
      $display("[TB] FAIL start_wait_done: got over=%b score=%0d round=%0d, want 1 %0d 3",
               over_a, score_a, round_a, exp_score);
    end
  endtask

  task automatic test_random;
    int idx, lit, act;
    bit ok;
    for (int g = 0; g < 3; g++) begin
      exp_score = 0; exp_miss = 0; exp_round = 0;
      pulse_start_a();
      for (int r = 0; r < 3; r++) begin
        act = $urandom_range(0, 3);
        play_round_a(act, $urandom_range(0, 10), idx, ok, lit);
        n_checks++;
        if (!ok || idx == last_idx_a) begin
          n_fail++;
          $display("[TB] FAIL random_target: got ok=%b idx=%0d prev=%0d, want lit and different",
                   ok, idx, last_idx_a);
        end
        if (ok) last_idx_a = idx;
        n_checks++;
        if (score_a !== 6'(exp_score) || miss_a !== 6'(exp_miss) || round_a !== 8'(exp_round)) begin
          n_fail++;
          $display("[TB] FAIL random_counts: got score=%0d miss=%0d round=%0d, want %0d %0d %0d",
                   score_a, miss_a, round_a, exp_score, exp_miss, exp_round);
        end
      end
      tick();
      n_checks++;
      if (over_a !== 1'b1 || led_a !== 4'hF) begin
        n_fail++;
        $display("[TB] FAIL random_done: got over=%b led=%h, want 1 f", over_a, led_a);
      end
    end
  endtask

  task automatic test_mid_game_reset;
    int idx, lit;
    bit ok;
    exp_score = 0; exp_miss = 0; exp_round = 0;
    pulse_start_a();
    for (int r = 0; r < 2; r++) begin
      play_round_a(0, 1, idx, ok, lit);
      if (ok) last_idx_a = idx;
    end
    wait_lit_a(idx, ok);
    n_checks++;
    if (!ok || score_a !== 6'd2) begin
      n_fail++;
      $display("[TB] FAIL reset_setup: got ok=%b score=%0d, want lit with score 2", ok, score_a);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({led_a, score_a, miss_a, round_a, over_a} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: got led=%h score=%0d miss=%0d round=%0d over=%b, want all 0",
               led_a, score_a, miss_a, round_a, over_a);
    end
    tick();
    tick();
    n_checks++;
    if (led_a !== 4'h0 || over_a !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got led=%h over=%b, want stay idle", led_a, over_a);
    end
    last_idx_a = -1;
    exp_score = 0; exp_miss = 0; exp_round = 0;
    pulse_start_a();
    play_round_a(0, 0, idx, ok, lit);
    n_checks++;
    if (!ok || score_a !== 6'd1 || miss_a !== 6'd0 || round_a !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL reset_fresh: got ok=%b score=%0d miss=%0d round=%0d, want 1 0 1",
               ok, score_a, miss_a, round_a);
    end
  endtask

  task automatic test_saturation;
    int idx, prev, exp_b;
    bit ok;
    prev  = -1;
    exp_b = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int r = 0; r < 200; r++) begin
      ok  = 1'b0;
      idx = -1;
      for (int i = 0; i < 200 && !ok; i++) begin
        tick();
        if ($onehot(led_b)) begin
          ok = 1'b1;
          for (int b = 0; b < 5; b++) if (led_b[b]) idx = b;
        end
      end
      n_checks++;
      if (!ok || idx == prev) begin
        n_fail++;
        $display("[TB] FAIL sat_target: got ok=%b led=%h prev=%0d in round %0d, want new one-hot",
                 ok, led_b, prev, r);
        break;
      end
      prev = idx;
      sw_b[idx] = ~sw_b[idx];
      tick();
      exp_b = (exp_b < 7) ? exp_b + 1 : 7;
      n_checks++;
      if (score_b !== 3'(exp_b) || round_b !== 8'(r + 1) || led_b !== 5'h0) begin
        n_fail++;
        $display("[TB] FAIL sat_round: got score=%0d round=%0d led=%h, want %0d %0d 0",
                 score_b, round_b, led_b, exp_b, r + 1);
      end
    end
    tick();
    n_checks++;
    if (over_b !== 1'b1 || led_b !== 5'h1F || score_b !== 3'd7 || miss_b !== 3'd0 || round_b !== 8'd200) begin
      n_fail++;
      $display("[TB] FAIL sat_done: got over=%b led=%h score=%0d miss=%0d round=%0d, want 1 1f 7 0 200",
               over_b, led_b, score_b, miss_b, round_b);
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_hits();
    test_timeout();
    test_wrong_toggle();
    test_start_in_wait();
    test_random();
    test_mid_game_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
